// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates jump / milestone / game-over sound events onto a
// single square-wave tone generator. Each event plays a fixed note sequence
// whose note lengths are measured in 60 Hz game ticks. Higher-priority events
// preempt lower ones; jump may retrigger itself, the others ignore retriggers.
module sound_sequencer #(
  parameter logic [15:0] JUMP_HALF  = 16'd14304,
  parameter logic [15:0] MS1_HALF   = 16'd19090,
  parameter logic [15:0] MS2_HALF   = 16'd14304,
  parameter logic [15:0] GO1_HALF   = 16'd28608,
  parameter logic [15:0] GO2_HALF   = 16'd38180,
  parameter logic [15:0] GO3_HALF   = 16'd57216,
  parameter logic [3:0]  JUMP_TICKS = 4'd6,
  parameter logic [3:0]  NOTE_TICKS = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_tick,
  input  logic       jump_pulse,
  input  logic       milestone_pulse,
  input  logic       game_over_pulse,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam int unsigned TONE_W = 16;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned ID_W   = 2;

  localparam logic [ID_W-1:0] ID_NONE = 2'd0;
  localparam logic [ID_W-1:0] ID_JUMP = 2'd1;
  localparam logic [ID_W-1:0] ID_MS   = 2'd2;
  localparam logic [ID_W-1:0] ID_GO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_JUMP = 3'd1,
    S_MS1  = 3'd2,
    S_MS2  = 3'd3,
    S_GO1  = 3'd4,
    S_GO2  = 3'd5,
    S_GO3  = 3'd6
  } state_e;

  state_e            state_q;
  logic [TONE_W-1:0] tone_cnt_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tone_q;
  logic              busy_q;
  logic [ID_W-1:0]   active_id_q;

  logic [ID_W-1:0]   req_pri_c;
  logic              accept_c;
  state_e            entry_state_c;
  state_e            next_note_c;
  logic [TONE_W-1:0] half_c;
  logic [TICK_W-1:0] dur_c;
  logic              note_done_c;
  logic              tone_wrap_c;

  // Sequence id that owns the tone generator in a given state.
  function automatic logic [ID_W-1:0] id_of(input state_e s);
    case (s)
      S_JUMP:               id_of = ID_JUMP;
      S_MS1, S_MS2:         id_of = ID_MS;
      S_GO1, S_GO2, S_GO3:  id_of = ID_GO;
      default:              id_of = ID_NONE;
    endcase
  endfunction

  // Request arbitration: highest simultaneous pulse wins, others are dropped.
  always_comb begin
    req_pri_c     = ID_NONE;
    entry_state_c = S_IDLE;
    if (game_over_pulse) begin
      req_pri_c     = ID_GO;
      entry_state_c = S_GO1;
    end else if (milestone_pulse) begin
      req_pri_c     = ID_MS;
      entry_state_c = S_MS1;
    end else if (jump_pulse) begin
      req_pri_c     = ID_JUMP;
      entry_state_c = S_JUMP;
    end
    // Strictly higher priority preempts; only jump may restart itself.
    accept_c = (req_pri_c > active_id_q) ||
               ((req_pri_c == ID_JUMP) && (active_id_q == ID_JUMP));
  end

  // Per-note tone half period, note duration and successor note.
  always_comb begin
    half_c      = 16'd1;
    dur_c       = NOTE_TICKS;
    next_note_c = S_IDLE;
    case (state_q)
      S_JUMP: begin
        half_c      = JUMP_HALF;
        dur_c       = JUMP_TICKS;
        next_note_c = S_IDLE;
      end
      S_MS1: begin
        half_c      = MS1_HALF;
        next_note_c = S_MS2;
      end
      S_MS2: begin
        half_c      = MS2_HALF;
        next_note_c = S_IDLE;
      end
      S_GO1: begin
        half_c      = GO1_HALF;
        next_note_c = S_GO2;
      end
      S_GO2: begin
        half_c      = GO2_HALF;
        next_note_c = S_GO3;
      end
      S_GO3: begin
        half_c      = GO3_HALF;
        next_note_c = S_IDLE;
      end
      default: begin
        half_c      = 16'd1;
        dur_c       = NOTE_TICKS;
        next_note_c = S_IDLE;
      end
    endcase
    note_done_c = (state_q != S_IDLE) && game_tick &&
                  (tick_cnt_q == (dur_c - TICK_W'(1)));
    tone_wrap_c = (tone_cnt_q == (half_c - TONE_W'(1)));
  end

  // Sequencer FSM with tone/tick counters; every note entry restarts both
  // counters and the tone phase, and an accepted request beats an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tone_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      tone_q      <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= ID_NONE;
    end else if (accept_c) begin
      state_q     <= entry_state_c;
      tone_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      tone_q      <= 1'b0;
      busy_q      <= 1'b1;
      active_id_q <= req_pri_c;
    end else if (note_done_c) begin
      state_q     <= next_note_c;
      tone_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      tone_q      <= 1'b0;
      busy_q      <= (next_note_c != S_IDLE);
      active_id_q <= id_of(next_note_c);
    end else if (state_q == S_IDLE) begin
      tone_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      tone_q      <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= ID_NONE;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(game_tick);
      if (tone_wrap_c) begin
        tone_cnt_q <= '0;
        tone_q     <= ~tone_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TONE_W'(1);
      end
    end
  end

  assign sound     = tone_q & ~mute;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer: directed scenarios plus a random phase, all
// checked every cycle against a sequence-level reference model.
module tb_sound_sequencer;

  localparam int JH = 4;
  localparam int M1 = 3;
  localparam int M2 = 5;
  localparam int G1 = 6;
  localparam int G2 = 7;
  localparam int G3 = 9;
  localparam int JT = 2;
  localparam int NT = 2;
  localparam int TICK_PERIOD = 100;

  logic       clk;
  logic       rst_n;
  logic       game_tick;
  logic       jump_pulse;
  logic       milestone_pulse;
  logic       game_over_pulse;
  logic       mute;
  logic       sound;
  logic       busy;
  logic [1:0] active_id;

  int checks;
  int failures;

  // Reference model: active sequence (0 none, 1 jump, 2 milestone, 3 game over),
  // note index inside it, cycle the note started, ticks counted in the note.
  int cyc;
  int m_seq;
  int m_note;
  int m_entry;
  int m_ticks;

  sound_sequencer #(
    .JUMP_HALF (16'(JH)),
    .MS1_HALF  (16'(M1)),
    .MS2_HALF  (16'(M2)),
    .GO1_HALF  (16'(G1)),
    .GO2_HALF  (16'(G2)),
    .GO3_HALF  (16'(G3)),
    .JUMP_TICKS(4'(JT)),
    .NOTE_TICKS(4'(NT))
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_tick      (game_tick),
    .jump_pulse     (jump_pulse),
    .milestone_pulse(milestone_pulse),
    .game_over_pulse(game_over_pulse),
    .mute           (mute),
    .sound          (sound),
    .busy           (busy),
    .active_id      (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int half_of(input int s, input int n);
    if (s == 1) return JH;
    if (s == 2) return (n == 0) ? M1 : M2;
    return (n == 0) ? G1 : ((n == 1) ? G2 : G3);
  endfunction

  function automatic int dur_of(input int s);
    return (s == 1) ? JT : NT;
  endfunction

  function automatic int notes_of(input int s);
    return (s == 1) ? 1 : ((s == 2) ? 2 : 3);
  endfunction

  function automatic bit tick_due();
    return ((cyc + 1) % TICK_PERIOD) == 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seq   = 0;
    m_note  = 0;
    m_entry = 0;
    m_ticks = 0;
  endtask

  task automatic model_edge(input bit jp, input bit mp, input bit gp, input bit tk);
    int p;
    p = gp ? 3 : (mp ? 2 : (jp ? 1 : 0));
    if (p > m_seq || (p == 1 && m_seq == 1)) begin
      m_seq   = p;
      m_note  = 0;
      m_entry = cyc;
      m_ticks = 0;
    end else if (m_seq != 0 && tk) begin
      m_ticks++;
      if (m_ticks == dur_of(m_seq)) begin
        m_note++;
        m_ticks = 0;
        m_entry = cyc;
        if (m_note == notes_of(m_seq)) begin
          m_seq  = 0;
          m_note = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic exp_sound;
    if (m_seq == 0) exp_sound = 1'b0;
    else exp_sound = (((cyc - m_entry) / half_of(m_seq, m_note)) % 2 == 1) & ~mute;
    chk("busy", 16'(busy), 16'(m_seq != 0));
    chk("active_id", 16'(active_id), 16'(m_seq));
    chk("sound", 16'(sound), 16'(exp_sound));
  endtask

  // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
  task automatic step(input bit jp, input bit mp, input bit gp, input bit tk);
    jump_pulse      = jp;
    milestone_pulse = mp;
    game_over_pulse = gp;
    game_tick       = tk;
    @(posedge clk);
    cyc++;
    model_edge(jp, mp, gp, tk);
    #1;
    jump_pulse      = 1'b0;
    milestone_pulse = 1'b0;
    game_over_pulse = 1'b0;
    game_tick       = 1'b0;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tick_due());
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy === 1'b1 && n < bound) begin
      step(1'b0, 1'b0, 1'b0, tick_due());
      n++;
    end
    chk(tag, 16'(busy), 16'd0);
  endtask

  initial begin
    int n;
    int nt;
    bit tk;
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    rst_n           = 1'b0;
    game_tick       = 1'b0;
    jump_pulse      = 1'b0;
    milestone_pulse = 1'b0;
    game_over_pulse = 1'b0;
    mute            = 1'b0;
    model_reset();

    // Reset state
    #22;
    chk("rst_sound", 16'(sound), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_id", 16'(active_id), 16'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    run(5);

    // Single jump: busy/id next edge, sound rises 4 clk after entry, period 8
    step(1'b1, 1'b0, 1'b0, tick_due());
    chk("jump_busy", 16'(busy), 16'd1);
    chk("jump_id", 16'(active_id), 16'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, tick_due());
      if (i == 3) chk("jump_low_at3", 16'(sound), 16'd0);
      if (i == 4) chk("jump_rise_at4", 16'(sound), 16'd1);
      if (i == 7) chk("jump_high_at7", 16'(sound), 16'd1);
      if (i == 8) chk("jump_fall_at8", 16'(sound), 16'd0);
    end
    run_until_idle("jump_end", 400);
    chk("jump_end_sound", 16'(sound), 16'd0);
    chk("jump_end_id", 16'(active_id), 16'd0);

    // Milestone: two notes, id 2 throughout
    step(1'b0, 1'b1, 1'b0, tick_due());
    chk("ms_id", 16'(active_id), 16'd2);
    run_until_idle("ms_end", 500);

    // Game over preempts a playing jump; jump never resumes
    step(1'b1, 1'b0, 1'b0, tick_due());
    run(37);
    step(1'b0, 1'b0, 1'b1, tick_due());
    chk("preempt_id", 16'(active_id), 16'd3);
    chk("preempt_sound", 16'(sound), 16'd0);
    run_until_idle("go_end", 800);

    // All three at once, then ignored jump and ignored game-over retrigger in GO2
    step(1'b1, 1'b1, 1'b1, tick_due());
    chk("simul_id", 16'(active_id), 16'd3);
    run(3);
    step(1'b1, 1'b0, 1'b0, tick_due());
    chk("jump_in_go_id", 16'(active_id), 16'd3);
    n = 0;
    while (!(m_seq == 3 && m_note == 1) && n < 400) begin
      step(1'b0, 1'b0, 1'b0, tick_due());
      n++;
    end
    chk("reach_go2", 16'(n < 400), 16'd1);
    run(11);
    step(1'b0, 1'b0, 1'b1, tick_due());
    chk("go_retrig_id", 16'(active_id), 16'd3);
    run(4);
    // Asynchronous reset mid-GO2
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sound", 16'(sound), 16'd0);
    chk("async_rst_busy", 16'(busy), 16'd0);
    chk("async_rst_id", 16'(active_id), 16'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    run(3);

    // Jump retrigger on the same edge as its last tick extends by JT ticks
    step(1'b1, 1'b0, 1'b0, tick_due());
    n = 0;
    while (!(m_seq == 1 && m_ticks == JT - 1 && tick_due()) && n < 400) begin
      step(1'b0, 1'b0, 1'b0, tick_due());
      n++;
    end
    chk("reach_last_tick", 16'(n < 400), 16'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_busy", 16'(busy), 16'd1);
    chk("restart_id", 16'(active_id), 16'd1);
    nt = 0;
    n  = 0;
    while (busy === 1'b1 && n < 400) begin
      tk = tick_due();
      step(1'b0, 1'b0, 1'b0, tk);
      if (tk) nt++;
      n++;
    end
    chk("restart_ticks", 16'(nt), 16'(JT));

    // Muted milestone: silent, sequence unchanged
    mute = 1'b1;
    step(1'b0, 1'b1, 1'b0, tick_due());
    n = 0;
    nt = 0;
    while (busy === 1'b1 && n < 500) begin
      step(1'b0, 1'b0, 1'b0, tick_due());
      if (sound !== 1'b0) nt++;
      n++;
    end
    chk("mute_silent", 16'(nt), 16'd0);
    chk("mute_end", 16'(busy), 16'd0);
    mute = 1'b0;

    // Random pulses, ticks and mute
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(199) == 0) mute = ~mute;
      step($urandom_range(29) == 0, $urandom_range(59) == 0,
           $urandom_range(119) == 0, $urandom_range(24) == 0);
    end
    mute = 1'b0;
    run_until_idle("rand_end", 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
